sdram_pll_reset_ctrl: RTL

//  Drives the sys PLL reset and consumes the PLL lock indication.
//  - Generates a timed pll_rst pulse.
//  - Synchronises pll_locked into the refclk domain and qualifies it as stable.
//  - Releases sys_rst_out to the SDRAM controller only after a hold period.
//  - Re-arms on lock loss; retries on lock timeout; latches fault after MAX_RETRIES.

---
 rtl/sdram_pll_rst_pkg.sv | 29 ++
 rtl/sdram_bit_sync_2ff.sv | 24 ++
 rtl/sdram_pll_reset_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/sdram_pll_rst_pkg.sv
// Shared types and helpers for the SDRAM PLL reset controller.
package sdram_pll_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN,
    FAULT
  } state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int max_cycles(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The shared counter only ever has to reach (cycles - 1).
  function automatic bit cnt_w_fits(int cnt_w, int cycles);
    return (cycles <= 1) || ($clog2(cycles) <= cnt_w);
  endfunction

endpackage

// File: rtl/sdram_bit_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sdram_bit_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdram_pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock, then releases the SDRAM reset.
module sdram_pll_reset_ctrl
  import sdram_pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 64,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst_out,
  output logic                  ready,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int MAX_CYC = max_cycles(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                      LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);

  if (!cnt_w_fits(CNT_W, MAX_CYC) || MAX_RETRIES < 1 || MAX_RETRIES > 3) begin : g_bad_params
    $error("sdram_pll_reset_ctrl: CNT_W too narrow or MAX_RETRIES outside 1..3");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [1:0]       retry, retry_nxt;
  logic             loss_inc;
  logic             locked_s;

  sdram_bit_sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) state <= PLL_RST;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    loss_inc  = 1'b0;
    unique case (state)
      PLL_RST:
        if (count == CNT_W'(PLL_RST_CYCLES - 1)) state_nxt = WAIT_LOCK;
      WAIT_LOCK:
        if (locked_s) begin
          state_nxt = STABLE;
        end else if (count == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_nxt = retry + 2'd1;
          state_nxt = (retry_nxt == 2'(MAX_RETRIES)) ? FAULT : PLL_RST;
        end
      STABLE:
        if (!locked_s)                                    state_nxt = WAIT_LOCK;
        else if (count == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_nxt = HOLD;
      HOLD:
        if (!locked_s) begin
          state_nxt = PLL_RST;
        end else if (count == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end
      RUN:
        if (!locked_s) begin
          state_nxt = PLL_RST;
          loss_inc  = 1'b1;
        end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = PLL_RST;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      count           <= '0;
      retry           <= '0;
      lock_loss_count <= '0;
      pll_rst         <= 1'b1;
      sys_rst_out     <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      count <= (state_nxt != state) ? '0 : count + 1'b1;
      retry <= retry_nxt;
      if (loss_inc && lock_loss_count != '1) lock_loss_count <= lock_loss_count + 1'b1;
      pll_rst     <= (state_nxt == PLL_RST);
      sys_rst_out <= (state_nxt != RUN);
      ready       <= (state_nxt == RUN);
      fault       <= (state_nxt == FAULT);
    end
  end

endmodule
